// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/half/word loads and stores over a single-ported word memory.
// Optional misalignment/reserved-size trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_ctrl #(
  parameter bit RESP_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [HALF_W-1:0]   wdata_q, wdata_d;

  logic                req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
  logic [XLEN-1:0]     rsp_rdata_d, mem_addr_d, mem_wdata_d;

  logic                bad_req;
  logic [7:0]          byte_sel;
  logic [HALF_W-1:0]   half_sel;
  logic [XLEN-1:0]     load_data;
  logic [XLEN-1:0]     merged;

  // Trap condition evaluated on the incoming request while in IDLE
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    bad_req = (req_size == 2'b11) ||
              ((req_size == SZ_HALF) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    bad_req = 1'b0;
`endif
  end

  // Lane extraction for loads and read-modify-write merge for sub-word stores
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: HALF_W];
    case (size_q)
      SZ_BYTE: load_data = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                   merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    mem_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata[HALF_W-1:0];
          if (bad_req) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size[1]) begin
            state_d     = WR;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = merged;
        end else begin
          state_d     = RESP;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (!RESP_HOLD) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_we_d    = (state_d == WR);
    mem_addr_d  = ((state_d == RD) || (state_d == WR)) ? {addr_d[XLEN-1:2], 2'b00} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a word-array reference model predicts data, errors, latency and writes.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, follow it to completion and compare against the reference model
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] got);
    logic [31:0] w, v, mask, data, new_w, exp_rd;
    logic        bad;
    int          sh, lat, cyc, we_cnt;
    w   = ref_mem[addr[7:2]];
    sh  = (size == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
`ifdef LSU_MISALIGN_CHECK_EN
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    mask = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (size[1]) sh = 0;
    v = (w >> sh) & mask;
    if (!uns && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
    data  = (wdata & mask) << sh;
    new_w = (w & ~(mask << sh)) | data;
    exp_rd = (bad || we) ? 32'h0 : v;
    lat = bad ? 1 : (!we || size[1]) ? 2 : 3;

    chk("idle_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    cyc = 1; we_cnt = 0;
    while (!rsp_valid && cyc < 8) begin
      chk("busy_ready", 32'(req_ready), 32'h0);
      if (mem_we) begin
        we_cnt++;
        chk("wr_addr", mem_addr, {addr[31:2], 2'b00});
        chk("wr_data", mem_wdata, new_w);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("we_pulses", 32'(we_cnt), (we && !bad) ? 32'h1 : 32'h0);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(bad));
    got = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_we", 32'(mem_we), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'h0);
    chk("post_ready", 32'(req_ready), 32'h1);
    chk("post_rdata", rsp_rdata, exp_rd);
    if (we && !bad) ref_mem[addr[7:2]] = new_w;
    chk("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h80FF_7F01; ref_mem[0] = 32'h80FF_7F01;
    mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 0, got);
    chk("lbu_1", got, 32'h0000_007F);
    do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 0, got);
    chk("lb_3", got, 32'hFFFF_FF80);
    do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 0, got);
    chk("lh_2", got, 32'hFFFF_80FF);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AB, 0, got);
    chk("sb_6_word", mem[1], 32'h11AB_3344);
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 5, got);
    chk("sw_8_word", mem[2], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, got);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_2_trap", got, 32'h0);
`else
    chk("lw_2_word", got, 32'h80FF_7F01);
`endif

    // Reset lands while the sub-word store to 0x10 is in its write cycle
    chk("sh_idle_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sh_in_wr", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    chk("abort_word", mem[4], ref_mem[4]);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'h0);

    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
             $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: RESP_HOLD, 1, 1 = rsp_rdata/rsp_err hold their last value after the handshake; 0 = they return to zero in IDLE.
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  core request valid.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: req_unsigned  input  1  load zero-extends if 1, sign-extends if 0.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: rsp_valid  output  1  response valid.
REQ-012 SHALL have port: rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port: rsp_rdata  output  32  extended load data; 0 for stores.
REQ-014 SHALL have port: rsp_err  output  1  misaligned/reserved request.
REQ-015 SHALL have port: mem_we  output  1  word memory write enable (write on rising clk).
REQ-016 SHALL have port: mem_addr  output  32  byte address to memory, always {addr[31:2],2'b00}.
REQ-017 SHALL have port: mem_wdata  output  32  full word written.
REQ-018 SHALL have port: mem_rdata  input  32  combinational read data for mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL on accept register we/size/unsigned/addr/wdata; load -> RD; word store -> WR; byte/half store -> RD.
REQ-021 SHALL in RD drive mem_addr, sample mem_rdata at end of cycle; load -> RESP with extracted data; sub-word store -> WR with merged word registered.
REQ-022 SHALL merge little-endian: byte lane addr[1:0], half lane addr[1]; untouched bytes keep the read value.
REQ-023 SHALL in WR assert mem_we for exactly one cycle with mem_wdata = merged/full word, then -> RESP.
REQ-024 SHALL extract loads by lane and extend per req_unsigned to 32 bits; word loads pass through.
REQ-025 SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err in RESP until rsp_ready=1, then -> IDLE; a new request may be accepted the following cycle.
REQ-026 SHALL give latency accept-edge to rsp_valid: load 2 cycles, word store 2, sub-word store 3.
REQ-027 SHALL drive mem_we=0 and mem_wdata=0 outside WR; mem_addr=0 in IDLE.

Reset
REQ-028 SHALL on rst_n=0 go immediately to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 SHALL abort any in-flight operation on reset; no memory write occurs after rst_n falls, and no response is issued for it.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_CHECK_EN defined, flag half with addr[0]=1, word with addr[1:0]!=0, or size=11: IDLE -> RESP in 1 cycle, rsp_err=1, rsp_rdata=0, no memory access.
REQ-031 SHALL, without LSU_MISALIGN_CHECK_EN, tie rsp_err=0, treat size=11 as word, ignore addr[0] for half and addr[1:0] for word.

Verification
REQ-032 SHALL cover: mem word 0x0 = 0x80FF_7F01; lbu addr 0x1 -> rsp_rdata=0x0000_007F; lb addr 0x3 -> 0xFFFF_FF80; lh addr 0x2 -> 0xFFFF_80FF.
REQ-033 SHALL cover: sb 0xAB to addr 0x6, word 0x4 = 0x1122_3344 -> one mem_we pulse, mem_wdata=0x11AB_3344, rsp_valid 3 cycles after accept.
REQ-034 SHALL cover: sw 0xDEAD_BEEF addr 0x8 -> mem_we in cycle 1 only, mem_addr=0x8, rsp_valid at cycle 2; rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, req_ready stays 0.
REQ-035 SHALL cover: with LSU_MISALIGN_CHECK_EN, lw addr 0x2 -> rsp_err=1 after 1 cycle, mem_we never 1; without it, same request -> reads word 0x0, rsp_err=0.
REQ-036 SHALL cover: rst_n pulsed low during WR of sh addr 0x10 -> mem_we drops immediately, word 0x10 unchanged, rsp_valid=0, req_ready=1.
